// File: rtl/seq_alu.sv
// Registered ALU with stored Z/N/C/V flags, ripple-carry adder
// and a shift-add multiplier that takes WIDTH steps.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       func,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SUB = 3'd1;
  localparam logic [2:0] F_AND = 3'd2;
  localparam logic [2:0] F_OR  = 3'd3;
  localparam logic [2:0] F_XOR = 3'd4;
  localparam logic [2:0] F_PAS = 3'd5;
  localparam logic [2:0] F_ADC = 3'd6;
  localparam logic [2:0] F_MUL = 3'd7;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t state_q, state_d;

  logic             accept;
  logic             mul_step;
  logic             mul_last;
  logic [CW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       flg_q;
  logic             done_q;

  logic [WIDTH-1:0] add_y;
  logic [WIDTH-1:0] add_s;
  logic [WIDTH:0]   cy;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept && func == F_MUL) state_d = MUL_BUSY;
      MUL_BUSY: if (mul_last) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = ena && (state_q == IDLE);
    accept   = in_ready && in_valid;
    mul_step = ena && (state_q == MUL_BUSY);
    mul_last = mul_step && (cnt_q == CW'(WIDTH - 1));
  end

  // One carry chain serves ADD, SUB (inverted b, cin=1) and ADC.
  always_comb begin
    add_y = (func == F_SUB) ? ~b : b;
    cy    = '0;
    cy[0] = (func == F_SUB) || ((func == F_ADC) && flg_q[1]);
    add_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      add_s[i]  = a[i] ^ add_y[i] ^ cy[i];
      cy[i+1]   = (a[i] & add_y[i]) | (cy[i] & (a[i] ^ add_y[i]));
    end
  end

  always_comb begin
    alu_r = add_s;
    alu_c = 1'b0;
    alu_v = 1'b0;
    unique case (func)
      F_ADD, F_SUB, F_ADC: begin
        alu_r = add_s;
        alu_c = cy[WIDTH];
        alu_v = cy[WIDTH] ^ cy[WIDTH-1];
      end
      F_AND:   alu_r = a & b;
      F_OR:    alu_r = a | b;
      F_XOR:   alu_r = a ^ b;
      F_PAS:   alu_r = a;
      default: alu_r = add_s;
    endcase
  end

  always_comb begin
    acc_d  = mplier_q[0] ? acc_q + mcand_q : acc_q;
    mul_hi = acc_d[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      flg_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (func == F_MUL) begin
          mcand_q  <= {{WIDTH{1'b0}}, a};
          mplier_q <= b;
          acc_q    <= '0;
          cnt_q    <= '0;
        end else begin
          res_q  <= alu_r;
          flg_q  <= {alu_r == '0, alu_r[WIDTH-1], alu_c, alu_v};
          done_q <= 1'b1;
        end
      end else if (mul_step) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CW'(1);
        if (mul_last) begin
          res_q  <= acc_d[WIDTH-1:0];
          flg_q  <= {acc_d[WIDTH-1:0] == '0, acc_d[WIDTH-1],
                     mul_hi != '0, mul_hi != '0};
          done_q <= 1'b1;
        end
      end
    end
  end

  assign result = res_q;
  assign flags  = flg_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed literal cases, then random traffic
// compared every cycle against a cycle-level behavioural model.
module tb_seq_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         ena = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   func = '0;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         done;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .func(func),
    .result(result), .flags(flags), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: tracks outputs at the granularity of clock edges.
  logic [W-1:0]   m_res = '0;
  logic [3:0]     m_flg = '0;
  logic           m_done = 1'b0;
  int             m_busy = 0;
  logic [2*W-1:0] m_prod = '0;

  always @(posedge clk or negedge rst_n) begin
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    if (!rst_n) begin
      m_res = '0; m_flg = '0; m_done = 1'b0; m_busy = 0;
    end else begin
      m_done = 1'b0;
      if (ena) begin
        if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0) begin
            m_res  = m_prod[W-1:0];
            c      = (m_prod[2*W-1:W] != 0);
            m_flg  = {m_res == 0, m_res[W-1], c, c};
            m_done = 1'b1;
          end
        end else if (in_valid) begin
          s = '0; c = 1'b0; v = 1'b0; r = '0;
          case (func)
            3'd0: begin
              s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
              v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd1: begin
              s = {1'b0, a} + {1'b0, ~b} + 1; r = s[W-1:0]; c = s[W];
              v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a;
            3'd6: begin
              s = {1'b0, a} + {1'b0, b} + m_flg[1]; r = s[W-1:0]; c = s[W];
              v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            default: begin
              m_prod = a * b;
              m_busy = W;
            end
          endcase
          if (func != 3'd7) begin
            m_res = r; m_flg = {r == 0, r[W-1], c, v}; m_done = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_result", result, m_res);
    chk("cmp_flags", flags, m_flg);
    chk("cmp_done", done, m_done);
    chk("cmp_ready", in_ready, ena && (m_busy == 0));
  end

  // Called at posedge+2 with the DUT idle; returns at accept edge + 2.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [2:0] f);
    a = x; b = y; func = f; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic op(input string nm, input logic [W-1:0] x,
                    input logic [W-1:0] y, input logic [2:0] f,
                    input logic [W-1:0] er, input logic [3:0] ef);
    issue(x, y, f);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_res"}, result, er);
    chk({nm, "_flg"}, flags, ef);
  endtask

  task automatic mul_wait(input string nm, input int stall_at,
                          input int exp_cyc, input logic [W-1:0] er,
                          input logic [3:0] ef);
    int  n;
    bit  rdy_bad;
    n = 0; rdy_bad = 0;
    while (n < 40) begin
      @(posedge clk); #2;
      n++;
      if (n == stall_at) ena = 1'b0;
      if (n == stall_at + 3) ena = 1'b1;
      if (done) break;
      if (in_ready) rdy_bad = 1;
    end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_cycles"}, n, exp_cyc);
    chk({nm, "_busy_ready"}, rdy_bad, 0);
    chk({nm, "_res"}, result, er);
    chk({nm, "_flg"}, flags, ef);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    ena = 1'b1;
    #2;
    chk("reset_result", result, 0);
    chk("reset_flags", flags, 0);
    chk("reset_done", done, 0);
    #18 rst_n = 1'b1;
    @(posedge clk); #2;
    chk("reset_ready", in_ready, 1);

    op("add_ovf", 8'h7F, 8'h01, 3'd0, 8'h80, 4'b0101);
    op("sub_eq",  8'h05, 8'h05, 3'd1, 8'h00, 4'b1010);
    op("sub_brw", 8'h03, 8'h05, 3'd1, 8'hFE, 4'b0100);
    op("add_cy",  8'hFF, 8'h01, 3'd0, 8'h00, 4'b1010);
    op("adc",     8'h01, 8'h01, 3'd6, 8'h03, 4'b0000);
    op("and",     8'hF0, 8'h3C, 3'd2, 8'h30, 4'b0000);

    issue(8'h0F, 8'h11, 3'd7);
    chk("mul1_ready_low", in_ready, 0);
    mul_wait("mul1", 0, 8, 8'hFF, 4'b0100);
    issue(8'h10, 8'h10, 3'd7);
    mul_wait("mul2", 0, 8, 8'h00, 4'b1011);

    // Back-to-back stream with in_valid held high.
    a = 8'h12; b = 8'h34; func = 3'd0; in_valid = 1'b1;
    @(posedge clk); #2;
    a = 8'h50; b = 8'h20; func = 3'd1;
    chk("strm_add_done", done, 1);
    chk("strm_add_res", result, 8'h46);
    @(posedge clk); #2;
    a = 8'hAA; b = 8'h0F; func = 3'd4;
    chk("strm_sub_done", done, 1);
    chk("strm_sub_res", result, 8'h30);
    chk("strm_sub_flg", flags, 4'b0010);
    @(posedge clk); #2;
    in_valid = 1'b0;
    chk("strm_xor_done", done, 1);
    chk("strm_xor_res", result, 8'hA5);
    chk("strm_xor_flg", flags, 4'b0100);

    issue(8'hC3, 8'h5A, 3'd7);
    mul_wait("mul_stall", 3, 11, 8'h8E, 4'b0111);

    // Asynchronous reset in the middle of a multiply.
    issue(8'h0F, 8'h11, 3'd7);
    @(posedge clk); #2;
    @(posedge clk); #4;
    rst_n = 1'b0;
    #1;
    chk("abort_result", result, 0);
    chk("abort_flags", flags, 0);
    chk("abort_done", done, 0);
    #12 rst_n = 1'b1;
    @(posedge clk); #2;
    chk("abort_ready", in_ready, 1);
    repeat (10) begin
      @(posedge clk); #2;
      chk("abort_no_done", done, 0);
    end

    // Random traffic; the per-cycle compare process does the checking.
    repeat (600) begin
      a        = W'($urandom);
      b        = W'($urandom);
      func     = 3'($urandom_range(0, 7));
      in_valid = ($urandom_range(0, 9) < 7);
      ena      = ($urandom_range(0, 9) != 0);
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    ena = 1'b1;
    repeat (W + 2) @(posedge clk);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Registered, parametrised-width ALU with a stored flag register, carry-chained add and a multi-cycle shift-add multiplier. It is the next generation of the team's 4-bit combinational ALU. Operands and function code enter through a valid/ready handshake. Result and flags are held in registers until the next operation completes. The block sits between the input switch/bidirectional pins and the display/output logic of a Tiny Tapeout tile.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥2).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  global enable; when low, state freezes and no operation is accepted.
- in_valid  in  1  operands and func are presented.
- in_ready  out  1  block can accept; equals ena & (state==IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- func  in  3  operation code (see Operation).
- result  out  WIDTH  registered result of the last completed operation.
- flags  out  4  registered {Z,N,C,V} of the last completed operation.
- done  out  1  one-cycle pulse in the cycle after result/flags update.

## Operation
- Accept: an operation is accepted on a rising edge where in_valid & in_ready. a, b and func are sampled at that edge only; later input changes are ignored.
- Function codes:
  - 0 ADD: result = a+b.
  - 1 SUB: result = a+~b+1.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 PASS: result = a.
  - 6 ADC: result = a+b+C_stored, where C_stored is flags[C] before the accept.
  - 7 MUL: unsigned a*b; result = low WIDTH bits.
- All arithmetic is modulo 2^WIDTH. The adder is one (WIDTH+1)-bit add with a true ripple carry per bit; no bit skips the carry chain.
- Flags:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - ADD/ADC: C = carry out; V = signed overflow (carry into MSB ^ carry out).
  - SUB: C = carry out, i.e. 1 = no borrow (a≥b unsigned); V = signed overflow.
  - AND/OR/XOR/PASS: C=0, V=0.
  - MUL: C = V = (upper WIDTH bits of the full product != 0).
- FSM states: IDLE and MUL_BUSY.
  - IDLE: a non-MUL accept writes result/flags at the accept edge; state stays IDLE. A MUL accept loads the multiplicand, the multiplier, a 2·WIDTH-bit product accumulator and an iteration counter (0); state goes to MUL_BUSY.
  - MUL_BUSY: each edge with ena=1 performs one shift-add step and increments the counter. The edge completing iteration WIDTH writes result/flags and returns to IDLE.
- ena=0 in MUL_BUSY: counter and accumulator hold; done is not generated. The operation resumes when ena returns.
- result and flags are not modified by anything other than a completed operation.
- Undriven/unused func values do not exist: all 8 codes are defined.

## Timing
- Reset (rst_n low, asynchronous): result=0, flags=0000, done=0, state=IDLE, counter=0. in_ready follows ena once rst_n is high.
- Reset asserted during MUL_BUSY aborts the multiply. Nothing is written and no done is produced.
- Non-MUL latency: 1 cycle. If accepted at edge N, result/flags are valid and done=1 after edge N, for one cycle.
- MUL latency: WIDTH+1 edges with ena held high. Accept at edge N; completion at edge N+WIDTH; done=1 during the following cycle. in_ready=0 from after edge N until after edge N+WIDTH.
- Back-to-back: with in_valid held high, non-MUL ops are accepted every cycle. done stays high continuously, and result changes every cycle.
- An accept in the same cycle that done is high is legal. ADC uses the flags present at its accept edge, which include those just written.

## Test plan (WIDTH=8)
- Reset, then ADD a=0x7F b=0x01 -> result=0x80, Z=0 N=1 C=0 V=1, done one cycle after accept.
- SUB a=0x05 b=0x05 -> 0x00, Z=1 C=1 V=0. SUB a=0x03 b=0x05 -> 0xFE, N=1 C=0.
- ADD 0xFF+0x01 -> 0x00, Z=1 C=1; then ADC 0x01+0x01 -> 0x03, C=0. Then AND 0xF0&0x3C -> 0x30, C=V=0.
- MUL 0x0F*0x11 -> 0xFF, C=V=0, done exactly 8 cycles after the accept-cycle done would appear, in_ready low throughout. MUL 0x10*0x10 -> 0x00, Z=1 C=V=1.
- Throughput and stall:
  - Stream ADD, SUB and XOR on consecutive cycles; each result appears one cycle after its accept.
  - Drop ena for 3 cycles mid-MUL; completion is delayed by exactly 3 cycles with the correct product.
- Pull rst_n low asynchronously (mid-cycle) during MUL_BUSY -> outputs go to 0 immediately, no done pulse, in_ready=1 after release with ena=1.
